// File: rtl/rib_spi_slave.sv
// SPI target on the RIB bus: oversampled pins, all four CPOL/CPHA modes, RX FIFO, TX holding byte.
// Optional interrupt output enabled by defining RIB_SPI_SLAVE_IRQ_EN.
module rib_spi_slave #(
  parameter int          RX_DEPTH = 4,
  parameter logic [7:0]  TX_DUMMY = 8'hFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  input  logic        spi_sck,
  input  logic        spi_ss_n,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        spi_miso_oe
`ifdef RIB_SPI_SLAVE_IRQ_EN
  ,output logic       int_sig_o
`endif
);

  localparam int AW = $clog2(RX_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(RX_DEPTH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;

  logic [1:0] sck_s, ss_s, mosi_s;
  logic       sck_q, ss_q;
  logic       sck_v, ss_v, mosi_v;

  logic       en, cpol, cpha, irq_en;
  logic [7:0] holding;
  logic       tx_pend, ovf;

  logic [1:0] state;
  logic [2:0] bitcnt;
  logic [6:0] shift_tx;
  logic [6:0] shift_rx;

  logic [7:0]  mem [RX_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count;

  logic active, edge_any, lead, trail, sample, advance;
  logic push, push_ok, pop, load, full, valid;
  logic wr_ctrl, wr_stat, wr_tx, wr_rx;
  logic [7:0] next_tx, rx_byte, head;
  logic unused_bits;

  assign unused_bits = ^{addr_i[31:4], addr_i[1:0], data_i[31:8]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_s  <= 2'b00;
      ss_s   <= 2'b11;
      mosi_s <= 2'b00;
      sck_q  <= 1'b0;
      ss_q   <= 1'b1;
    end else begin
      sck_s  <= {sck_s[0], spi_sck};
      ss_s   <= {ss_s[0], spi_ss_n};
      mosi_s <= {mosi_s[0], spi_mosi};
      sck_q  <= sck_s[1];
      ss_q   <= ss_s[1];
    end
  end

  assign sck_v  = sck_s[1];
  assign ss_v   = ss_s[1];
  assign mosi_v = mosi_s[1];

  assign active   = en & ~ss_v;
  assign edge_any = sck_v ^ sck_q;
  assign lead     = edge_any & (sck_q == cpol);
  assign trail    = edge_any & (sck_v == cpol);
  assign sample   = cpha ? trail : lead;
  assign advance  = cpha ? lead : trail;

  assign wr_ctrl = we_i & (addr_i[3:2] == 2'd0);
  assign wr_stat = we_i & (addr_i[3:2] == 2'd1);
  assign wr_tx   = we_i & (addr_i[3:2] == 2'd2);
  assign wr_rx   = we_i & (addr_i[3:2] == 2'd3);

  assign next_tx = tx_pend ? holding : TX_DUMMY;
  assign rx_byte = {shift_rx, mosi_v};
  assign push    = (state == ST_SHIFT) & active & sample & (bitcnt == 3'd7);
  assign load    = ((state == ST_LOAD) & active) | push;

  assign valid   = (count != '0);
  assign full    = (count == FULL_CNT);
  assign pop     = wr_rx & valid;
  assign push_ok = push & (~full | pop);
  assign head    = mem[rptr];

  assign spi_miso_oe = active;

  // Bit counter doubles as "first edge of byte" marker: no MISO advance at bitcnt 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      bitcnt   <= 3'd0;
      shift_tx <= 7'd0;
      shift_rx <= 7'd0;
      spi_miso <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          bitcnt <= 3'd0;
          if (active && ss_q) state <= ST_LOAD;
        end
        ST_LOAD: begin
          if (!active) begin
            state <= ST_IDLE;
          end else begin
            shift_tx <= next_tx[6:0];
            spi_miso <= next_tx[7];
            bitcnt   <= 3'd0;
            state    <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (!active) begin
            state  <= ST_IDLE;
            bitcnt <= 3'd0;
          end else if (sample) begin
            shift_rx <= rx_byte[6:0];
            bitcnt   <= bitcnt + 3'd1;
            if (bitcnt == 3'd7) begin
              shift_tx <= next_tx[6:0];
              spi_miso <= next_tx[7];
            end
          end else if (advance && bitcnt != 3'd0) begin
            spi_miso <= shift_tx[6];
            shift_tx <= {shift_tx[5:0], 1'b0};
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en      <= 1'b0;
      cpol    <= 1'b0;
      cpha    <= 1'b0;
      holding <= 8'd0;
      tx_pend <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        en   <= data_i[0];
        cpol <= data_i[1];
        cpha <= data_i[2];
      end
      if (load) tx_pend <= 1'b0;
      if (wr_tx) begin
        holding <= data_i[7:0];
        tx_pend <= 1'b1;
      end
      if (wr_stat && data_i[2]) ovf <= 1'b0;
      if (push && full && !pop) ovf <= 1'b1;
    end
  end

`ifdef RIB_SPI_SLAVE_IRQ_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_en    <= 1'b0;
      int_sig_o <= 1'b0;
    end else begin
      if (wr_ctrl) irq_en <= data_i[3];
      int_sig_o <= irq_en & (valid | ovf);
    end
  end
`else
  assign irq_en = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop)     rptr <= rptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= rx_byte;
  end

  always_comb begin
    data_o = 32'd0;
    case (addr_i[3:2])
      2'd0:    data_o[3:0] = {irq_en, cpha, cpol, en};
      2'd1:    data_o[4:0] = {active, tx_pend, ovf, full, valid};
      2'd2:    data_o[7:0] = holding;
      default: data_o[7:0] = valid ? head : 8'd0;
    endcase
  end

endmodule
